if_stage: RTL

Instruction-fetch stage of the pipelined MIPS core.
- Owns the PC register, which is loaded from the NPC block's output each time it advances.
- Drives a req/ready instruction-memory interface and presents {ID_PC, ID_instr, ID_valid} to decode through the IF/ID pipeline register.
- Handles decode stalls with a one-entry hold buffer.
- Handles redirects (branch/jump) by flushing and discarding in-flight responses.

---
 rtl/if_stage_pkg.sv | 5 +
 rtl/if_id_reg.sv | 25 ++
 rtl/if_stage.sv | 84 ++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: fetch-stage FSM encodings and reset PC shared by the IF stage
package if_stage_pkg;
    typedef enum logic [1:0] {IF_FETCH = 2'd0, IF_HOLD = 2'd1, IF_DRAIN = 2'd2} if_state_e;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush clears valid and wins over load
module if_id_reg (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_instr,
    output logic        ID_valid
);
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            ID_PC    <= '0;
            ID_instr <= '0;
            ID_valid <= 1'b0;
        end else if (flush) begin
            ID_valid <= 1'b0;
        end else if (load) begin
            ID_PC    <= pc;
            ID_instr <= instr;
            ID_valid <= 1'b1;
        end
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC register, one-entry stall buffer and redirect drain
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] NPC,
    input  logic        redirect,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IF_PC,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_instr,
    output logic        ID_valid
);
    if_state_e   state;
    logic [31:0] pc_q, hold_pc, hold_instr, drain_addr, id_pc_d, id_instr_d;
    logic        fetch, load, flush;
    always_comb begin
        fetch      = state == IF_FETCH;
        load       = !redirect && !stall && ((fetch && imem_ready) || state == IF_HOLD);
        flush      = redirect || (fetch && !imem_ready && !stall);
        id_pc_d    = fetch ? pc_q : hold_pc;
        id_instr_d = fetch ? imem_rdata : hold_instr;
    end
    // request is gated by rstn so nothing is issued while reset is held
    assign imem_req  = rstn && state != IF_HOLD;
    assign imem_addr = state == IF_DRAIN ? drain_addr : pc_q;
    assign IF_PC     = pc_q;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state      <= IF_FETCH;
            pc_q       <= RESET_PC;
            hold_pc    <= '0;
            hold_instr <= '0;
            drain_addr <= '0;
        end else begin
            case (state)
                IF_FETCH:
                    if (redirect) begin
                        pc_q <= NPC;
                        if (!imem_ready) begin
                            drain_addr <= pc_q;
                            state      <= IF_DRAIN;
                        end
                    end else if (imem_ready) begin
                        if (stall) begin
                            hold_pc    <= pc_q;
                            hold_instr <= imem_rdata;
                            state      <= IF_HOLD;
                        end else
                            pc_q <= NPC;
                    end
                IF_HOLD:
                    if (redirect || !stall) begin
                        pc_q  <= NPC;
                        state <= IF_FETCH;
                    end
                IF_DRAIN: begin
                    if (redirect)
                        pc_q <= NPC;
                    if (imem_ready)
                        state <= IF_FETCH;
                end
                default: state <= IF_FETCH;
            endcase
        end
    if_id_reg u_if_id (
        .clk     (clk),
        .rstn    (rstn),
        .load    (load),
        .flush   (flush),
        .pc      (id_pc_d),
        .instr   (id_instr_d),
        .ID_PC   (ID_PC),
        .ID_instr(ID_instr),
        .ID_valid(ID_valid)
    );
endmodule
